// File: rtl/modbus_msg_fifo_if.sv
// modbus_msg_fifo_if
//   CSR MSG window handshakes and the TX byte stream towards the UART bridge.
//   slave  : the message FIFO (drives RX head, TX ready and tx_b stream)
//   master : CSR block / bridge side
//   Signals:
//     csr_rx_data/csr_rx_eof/csr_rx_valid  RX head (fall-through), csr_rx_pop consumes it
//     csr_tx_data/csr_tx_push              CSR byte into TX FIFO, csr_tx_ready = not full
//     tx_b/tx_b_v/tx_b_rdy                 TX head byte to the bridge, valid/ready transfer
interface modbus_msg_fifo_if;
    logic [7:0] csr_rx_data;
    logic       csr_rx_eof;
    logic       csr_rx_valid;
    logic       csr_rx_pop;
    logic [7:0] csr_tx_data;
    logic       csr_tx_push;
    logic       csr_tx_ready;
    logic [7:0] tx_b;
    logic       tx_b_v;
    logic       tx_b_rdy;

    modport slave (
        output csr_rx_data, csr_rx_eof, csr_rx_valid,
        input  csr_rx_pop,
        input  csr_tx_data, csr_tx_push,
        output csr_tx_ready,
        output tx_b, tx_b_v,
        input  tx_b_rdy
    );

    modport master (
        input  csr_rx_data, csr_rx_eof, csr_rx_valid,
        output csr_rx_pop,
        output csr_tx_data, csr_tx_push,
        input  csr_tx_ready,
        input  tx_b, tx_b_v,
        output tx_b_rdy
    );
endinterface

// File: rtl/modbus_msg_fifo.sv
// modbus_msg_fifo
//   Host message buffer between the CSR MSG window and the UART bridge.
//   RX: bridge bytes stored with an end-of-frame flag, popped by CSR (first-word fall-through).
//   TX: CSR-pushed bytes streamed to the bridge with a valid/ready handshake.
//   Optional build macro MSG_TX_HOLD_EN: TX bytes are held until released by tx_commit.
//   Ports:
//     PCLK, PRESETn                         clock, asynchronous active-low reset
//     rx_b, rx_b_v, frame_start, frame_end  bridge RX byte stream and frame strobes
//     tx_commit                             end of host TX frame (hold build only)
//     cfg_msg_wm                            RX watermark in bytes ([AW:0]), 0 disables
//     rx_flush, tx_flush                    synchronous FIFO clears
//     rx_level, tx_level, rx_frames         occupancies and complete RX frames held
//     rx_ovf, wm_irq                        sticky RX overflow, registered watermark level
//     bus                                   CSR / bridge handshakes (modbus_msg_fifo_if.slave)
module modbus_msg_fifo #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [7:0]       rx_b,
    input  logic             rx_b_v,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             tx_commit,
    input  logic [15:0]      cfg_msg_wm,
    input  logic             rx_flush,
    input  logic             tx_flush,
    output logic [AW:0]      rx_level,
    output logic [AW:0]      tx_level,
    output logic [AW:0]      rx_frames,
    output logic             rx_ovf,
    output logic             wm_irq,
    modbus_msg_fifo_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    // ---------------- RX ----------------
    logic [7:0]       rx_mem [DEPTH];
    logic [DEPTH-1:0] rx_eof_bits;
    logic [AW-1:0]    rx_wr_ptr, rx_rd_ptr, rx_last;
    logic             rx_open;      // last written byte belongs to a frame not yet closed
    logic             rx_pop, rx_acc, rx_mark, rx_head_eof, rx_valid;
    logic [AW:0]      wm_thr;
    logic             unused_wm_hi;

    assign wm_thr       = cfg_msg_wm[AW:0];
    assign unused_wm_hi = ^cfg_msg_wm[15:AW+1];

    always_comb begin
        rx_valid    = (rx_level != '0);
        rx_pop      = bus.csr_rx_pop && rx_valid;
        rx_acc      = rx_b_v && ((rx_level != FULL) || rx_pop);
        rx_last     = rx_wr_ptr - AW'(1);
        rx_head_eof = rx_eof_bits[rx_rd_ptr];
        // Close an open frame on the newest stored byte. A frame_end riding on an
        // accepted byte marks that byte instead. If the only stored byte is being
        // popped this cycle the mark is dropped so rx_frames never counts a frame
        // that has already left the FIFO.
        rx_mark     = rx_open && (frame_start || (frame_end && !rx_acc)) && rx_valid
                      && !(rx_pop && (rx_level == ONE));
    end

    always_ff @(posedge PCLK) begin
        if (!rx_flush) begin
            if (rx_acc) begin
                rx_mem[rx_wr_ptr]      <= rx_b;
                rx_eof_bits[rx_wr_ptr] <= frame_end;
            end
            if (rx_mark) rx_eof_bits[rx_last] <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            rx_frames <= '0;
            rx_ovf    <= 1'b0;
            rx_open   <= 1'b0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
            rx_frames <= '0;
            rx_ovf    <= 1'b0;
            rx_open   <= 1'b0;
        end else begin
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + AW'(1);
            if (rx_acc) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            rx_level  <= rx_level + (AW+1)'(rx_acc) - (AW+1)'(rx_pop);
            rx_frames <= rx_frames + (AW+1)'(rx_mark) + (AW+1)'(rx_acc && frame_end)
                         - (AW+1)'(rx_pop && rx_head_eof);
            if (rx_b_v && !rx_acc) rx_ovf <= 1'b1;
            if (rx_acc)                         rx_open <= !frame_end;
            else if (frame_start || frame_end)  rx_open <= 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) wm_irq <= 1'b0;
        else          wm_irq <= (wm_thr != '0) && (rx_level >= wm_thr);
    end

    always_comb begin
        bus.csr_rx_valid = rx_valid;
        bus.csr_rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;
        bus.csr_rx_eof   = rx_valid && rx_head_eof;
    end

    // ---------------- TX ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic          tx_push, tx_pop, tx_out_v;
    logic [AW:0]   tx_level_nxt;

    always_comb begin
        tx_push      = bus.csr_tx_push && (tx_level != FULL);
        tx_pop       = tx_out_v && bus.tx_b_rdy;
        tx_level_nxt = tx_level + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end

    always_ff @(posedge PCLK) begin
        if (tx_push && !tx_flush) tx_mem[tx_wr_ptr] <= bus.csr_tx_data;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
            tx_level <= tx_level_nxt;
        end
    end

`ifdef MSG_TX_HOLD_EN
    // Bytes released by commits; a commit releases everything up to the tail,
    // including a byte pushed in the same cycle.
    logic [AW:0] tx_rel;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)       tx_rel <= '0;
        else if (tx_flush)  tx_rel <= '0;
        else if (tx_commit) tx_rel <= tx_level_nxt;
        else if (tx_pop)    tx_rel <= tx_rel - ONE;
    end

    assign tx_out_v = (tx_rel != '0);
`else
    logic unused_commit;
    assign unused_commit = tx_commit;
    assign tx_out_v      = (tx_level != '0);
`endif

    always_comb begin
        bus.csr_tx_ready = (tx_level != FULL);
        bus.tx_b_v       = tx_out_v;
        bus.tx_b         = tx_out_v ? tx_mem[tx_rd_ptr] : '0;
    end
endmodule

// File: tb/tb_modbus_msg_fifo.sv
module tb_modbus_msg_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          PCLK    = 1'b0;
    logic          PRESETn = 1'b1;
    logic [7:0]    rx_b    = '0;
    logic          rx_b_v  = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end   = 1'b0;
    logic          tx_commit   = 1'b0;
    logic [15:0]   cfg_msg_wm  = '0;
    logic          rx_flush    = 1'b0;
    logic          tx_flush    = 1'b0;
    logic [AW:0]   rx_level, tx_level, rx_frames;
    logic          rx_ovf, wm_irq;

    always #5 PCLK = ~PCLK;

    modbus_msg_fifo_if bus();

    modbus_msg_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .rx_b(rx_b), .rx_b_v(rx_b_v), .frame_start(frame_start), .frame_end(frame_end),
        .tx_commit(tx_commit), .cfg_msg_wm(cfg_msg_wm),
        .rx_flush(rx_flush), .tx_flush(tx_flush),
        .rx_level(rx_level), .tx_level(tx_level), .rx_frames(rx_frames),
        .rx_ovf(rx_ovf), .wm_irq(wm_irq),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // RX buffer as a queue of {eof, byte}; frames = number of eof-flagged entries held.
    logic [8:0] m_rxq[$];
    logic [7:0] m_txq[$];
    bit         m_open, m_ovf, m_wm;
    int         m_rel;

    function automatic bit m_tx_v();
`ifdef MSG_TX_HOLD_EN
        return m_rel != 0;
`else
        return m_txq.size() != 0;
`endif
    endfunction

    always @(posedge PCLK or negedge PRESETn) begin : model
        int rs, wm;
        bit pop, acc, mark, tpop, tpush;
        logic [8:0] e;
        if (!PRESETn) begin
            m_rxq.delete();
            m_txq.delete();
            m_open = 0; m_ovf = 0; m_wm = 0; m_rel = 0;
        end else begin
            rs   = m_rxq.size();
            wm   = int'(cfg_msg_wm[AW:0]);
            m_wm = (wm != 0) && (rs >= wm);
            pop  = bus.csr_rx_pop && (rs > 0);
            acc  = rx_b_v && ((rs < DEPTH) || pop);
            if (rx_flush) begin
                m_rxq.delete();
                m_ovf  = 0;
                m_open = 0;
            end else begin
                mark = m_open && (frame_start || (frame_end && !acc)) && (rs > 0) && !(pop && rs == 1);
                if (mark) begin
                    e = m_rxq[rs-1];
                    e[8] = 1'b1;
                    m_rxq[rs-1] = e;
                end
                if (pop) void'(m_rxq.pop_front());
                if (acc) m_rxq.push_back({frame_end, rx_b});
                if (rx_b_v && !acc) m_ovf = 1;
                if (acc)                            m_open = !frame_end;
                else if (frame_start || frame_end)  m_open = 0;
            end

            tpop  = m_tx_v() && bus.tx_b_rdy;
            tpush = bus.csr_tx_push && (m_txq.size() < DEPTH);
            if (tx_flush) begin
                m_txq.delete();
                m_rel = 0;
            end else begin
                if (tpop)  void'(m_txq.pop_front());
                if (tpush) m_txq.push_back(bus.csr_tx_data);
                if (tx_commit)  m_rel = m_txq.size();
                else if (tpop)  m_rel = m_rel - 1;
            end
        end
    end

    always @(negedge PCLK) begin : compare
        int fr;
        logic [8:0] h;
        fr = 0;
        foreach (m_rxq[i]) begin
            h = m_rxq[i];
            fr += int'(h[8]);
        end
        h = (m_rxq.size() != 0) ? m_rxq[0] : 9'h000;
        chk("rx_level",     int'(rx_level),  m_rxq.size());
        chk("rx_frames",    int'(rx_frames), fr);
        chk("rx_ovf",       int'(rx_ovf),    int'(m_ovf));
        chk("wm_irq",       int'(wm_irq),    int'(m_wm));
        chk("csr_rx_valid", int'(bus.csr_rx_valid), int'(m_rxq.size() != 0));
        chk("csr_rx_data",  int'(bus.csr_rx_data),  int'(h[7:0]));
        chk("csr_rx_eof",   int'(bus.csr_rx_eof),   int'(h[8]));
        chk("tx_level",     int'(tx_level),  m_txq.size());
        chk("csr_tx_ready", int'(bus.csr_tx_ready), int'(m_txq.size() < DEPTH));
        chk("tx_b_v",       int'(bus.tx_b_v), int'(m_tx_v()));
        chk("tx_b",         int'(bus.tx_b),   m_tx_v() ? int'(m_txq[0]) : 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle();
        rx_b_v = 0; frame_start = 0; frame_end = 0; tx_commit = 0;
        rx_flush = 0; tx_flush = 0;
        bus.csr_rx_pop = 0; bus.csr_tx_push = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic e);
        rx_b = b; rx_b_v = 1; frame_end = e;
        tick();
        idle();
    endtask

    task automatic pop_one();
        bus.csr_rx_pop = 1;
        tick();
        idle();
    endtask

    task automatic tx_push(input logic [7:0] b);
        bus.csr_tx_data = b; bus.csr_tx_push = 1;
        tick();
        idle();
    endtask

    logic [7:0] exp_d [4];

    initial begin
        bus.csr_rx_pop = 0; bus.csr_tx_data = '0; bus.csr_tx_push = 0; bus.tx_b_rdy = 0;
        #1 PRESETn = 0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_rx_level", int'(rx_level), 0);
        chk("rst_tx_ready", int'(bus.csr_tx_ready), 1);
        chk("rst_tx_b_v",   int'(bus.tx_b_v), 0);
        PRESETn = 1;
        tick();

        // Frame 01,03,00,10 with frame_end on the last byte
        exp_d = '{8'h01, 8'h03, 8'h00, 8'h10};
        for (int i = 0; i < 4; i++) rx_byte(exp_d[i], i == 3);
        chk("frm_level",  int'(rx_level), 4);
        chk("frm_frames", int'(rx_frames), 1);
        for (int i = 0; i < 4; i++) begin
            chk("frm_data", int'(bus.csr_rx_data), int'(exp_d[i]));
            chk("frm_eof",  int'(bus.csr_rx_eof),  (i == 3) ? 1 : 0);
            pop_one();
        end
        chk("frm_frames_end", int'(rx_frames), 0);
        chk("frm_valid_end",  int'(bus.csr_rx_valid), 0);

        // Overflow at full, then push+pop at full
        for (int i = 0; i <= DEPTH; i++) rx_byte(8'(i), 1'b0);
        chk("ovf_flag",  int'(rx_ovf), 1);
        chk("ovf_level", int'(rx_level), DEPTH);
        rx_b = 8'hEE; rx_b_v = 1; bus.csr_rx_pop = 1;
        tick();
        idle();
        chk("full_pp_level", int'(rx_level), DEPTH);
        chk("full_pp_head",  int'(bus.csr_rx_data), 1);
        bus.csr_rx_pop = 1;
        repeat (DEPTH - 1) tick();
        idle();
        chk("full_pp_kept", int'(bus.csr_rx_data), 8'hEE);
        chk("ovf_sticky",   int'(rx_ovf), 1);
        rx_flush = 1;
        tick();
        idle();
        chk("flush_level", int'(rx_level), 0);
        chk("flush_ovf",   int'(rx_ovf), 0);

        // Watermark 4
        cfg_msg_wm = 16'd4;
        for (int i = 0; i < 3; i++) rx_byte(8'h50 + 8'(i), 1'b0);
        tick();
        chk("wm_3", int'(wm_irq), 0);
        rx_byte(8'h53, 1'b0);
        chk("wm_4_same", int'(wm_irq), 0);
        tick();
        chk("wm_4_next", int'(wm_irq), 1);
        pop_one();
        chk("wm_pop_same", int'(wm_irq), 1);
        tick();
        chk("wm_pop_next", int'(wm_irq), 0);
        cfg_msg_wm = '0;
        rx_flush = 1;
        tick();
        idle();

        // TX back-pressure
        bus.tx_b_rdy = 0;
        tx_push(8'hAA);
        tx_push(8'hBB);
        tx_commit = 1;
        tick();
        idle();
        tick();
        chk("tx_hold_v",     int'(bus.tx_b_v), 1);
        chk("tx_hold_b",     int'(bus.tx_b), 8'hAA);
        chk("tx_hold_level", int'(tx_level), 2);
        bus.tx_b_rdy = 1;
        tick();
        chk("tx_second", int'(bus.tx_b), 8'hBB);
        chk("tx_lvl1",   int'(tx_level), 1);
        tick();
        chk("tx_lvl0",   int'(tx_level), 0);
        chk("tx_v0",     int'(bus.tx_b_v), 0);

`ifdef MSG_TX_HOLD_EN
        tx_push(8'h11);
        tx_push(8'h22);
        tx_push(8'h33);
        tick();
        chk("hold_nocommit_v", int'(bus.tx_b_v), 0);
        chk("hold_level",      int'(tx_level), 3);
        tx_commit = 1;
        tick();
        idle();
        chk("hold_b0", int'(bus.tx_b), 8'h11);
        tick();
        chk("hold_b1", int'(bus.tx_b), 8'h22);
        tick();
        chk("hold_b2", int'(bus.tx_b), 8'h33);
        tick();
        chk("hold_done_v", int'(bus.tx_b_v), 0);
`endif

        // Randomized traffic, alternating fill-heavy and drain-heavy windows
        for (int c = 0; c < 4000; c++) begin
            int pr;
            pr = ((c / 250) % 2 != 0) ? 20 : 70;
            if (c % 300 == 0) cfg_msg_wm = 16'($urandom_range(DEPTH + 1));
            rx_b            = 8'($urandom);
            rx_b_v          = ($urandom_range(99) < 50);
            frame_end       = ($urandom_range(99) < 15);
            frame_start     = ($urandom_range(99) < 8);
            bus.csr_rx_pop  = ($urandom_range(99) < pr);
            bus.csr_tx_data = 8'($urandom);
            bus.csr_tx_push = ($urandom_range(99) < 50);
            bus.tx_b_rdy    = ($urandom_range(99) < pr);
            tx_commit       = ($urandom_range(99) < 10);
            rx_flush        = ($urandom_range(199) == 0);
            tx_flush        = ($urandom_range(199) == 0);
            tick();
        end
        idle();

        // Asynchronous reset mid-stream with 5 RX and 3 TX bytes held
        rx_flush = 1; tx_flush = 1;
        tick();
        idle();
        cfg_msg_wm = 16'd2;
        bus.tx_b_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            rx_b = 8'h40 + 8'(i); rx_b_v = 1;
            bus.csr_tx_data = 8'h80 + 8'(i); bus.csr_tx_push = (i < 3);
            tick();
            idle();
        end
        tick();
        chk("pre_rst_rx", int'(rx_level), 5);
        chk("pre_rst_tx", int'(tx_level), 3);
        chk("pre_rst_wm", int'(wm_irq), 1);
        #2 PRESETn = 0;
        #1;
        chk("arst_rx_level", int'(rx_level), 0);
        chk("arst_tx_level", int'(tx_level), 0);
        chk("arst_rx_valid", int'(bus.csr_rx_valid), 0);
        chk("arst_tx_ready", int'(bus.csr_tx_ready), 1);
        chk("arst_tx_b_v",   int'(bus.tx_b_v), 0);
        chk("arst_wm_irq",   int'(wm_irq), 0);
        tick();
        PRESETn = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
